c1_sweep_checker: RTL and testbench
===================================

# c1_sweep_checker

Self-checking stimulus stage wrapped around the C1 logic-module cell. On a start pulse it drives every combination of the eight C1 inputs, samples the cell's F output after a programmable settle time, and compares it against a built-in golden model. It reports a mismatch count and pass/fail, so a C1 instance (or a netlist built from AND/OR/XOR/NOT gates) can be qualified on-chip rather than only in a bench.

## Interface
Parameters:
- SETTLE, default 1: cycles the drive is held before F is sampled (legal range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a sweep.
- f_in  in  1  F output of the C1 under test.
- vec  out  8  drive bus {SB,SA,S1,S0,A0,B0,A1,B1}; bit 7 is SB and bit 0 is B1, in C1 port order.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; held high until the next accepted start.
- pass  out  1  equals done && (err_cnt == 0).
- err_cnt  out  9  mismatch count, range 0..256.
- Only with FIRST_FAIL_EN:
  - ff_valid  out  1  a first mismatch has been captured.
  - ff_vec  out  8  vec value at the first mismatch.

## Operation
- Golden model, with f1 = SA ? A1 : A0 and f2 = SB ? B1 : B0:
  - F = (S0 | S1) ? f2 : f1
- FSM states:
  - IDLE: reset state.
  - RUN: sweeping.
  - DONE: results held.
- Transitions:
  - IDLE or DONE, start=1: go to RUN. Clear vec, err_cnt, the wait counter, done and ff_valid.
  - RUN: a wait counter counts 0..SETTLE.
    - When wait == SETTLE on a clock edge, sample f_in, compare it with golden(vec), and add 1 to err_cnt if they differ.
    - On that same edge, reset wait to 0 and increment vec.
    - If vec == 8'hFF on that edge, go to DONE instead of wrapping. vec then stays 8'hFF.
  - DONE: hold all results until start.
- start is ignored while in RUN.
- err_cnt cannot overflow because it is 9 bits wide and holds at most 256.
- All inputs are sampled only at clock edges. f_in must be stable at the compare edge.

## Timing
- Values after reset: vec=0, busy=0, done=0, pass=0, err_cnt=0, ff_valid=0, ff_vec=0, state IDLE, wait=0.
- Asserting rst mid-sweep aborts immediately to the reset values; no partial results are kept.
- busy goes high on the edge after start is sampled and drops on the edge where done rises.
- Each vector occupies SETTLE+1 cycles. A full sweep is 256*(SETTLE+1) cycles from start to done: 512 at SETTLE=1.
- vec changes only on the compare edge. It is therefore stable for SETTLE+1 cycles, and SETTLE full cycles of settle precede each sample.
- When start and the final compare edge fall in the same cycle, start is ignored and the block enters DONE.
- If start arrives in DONE, the first cycle of the new sweep shows the cleared outputs (done=0, err_cnt=0).

## Configuration
- FIRST_FAIL_EN:
  - Defined: ff_valid and ff_vec exist. On the first mismatch of a sweep, ff_vec latches vec and ff_valid rises. Later mismatches do not overwrite them. Both are cleared by reset or by an accepted start.
  - Undefined: these ports and registers are absent, and all other behaviour is identical.

## Structure
- Shared package/header c1_pkg:
  - Vector width constant (8).
  - FSM state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Bit-index constants for SB..B1 within vec.
- One sub-module, c1_golden: purely combinational reference model mapping vec[7:0] to F.
- The FSM, counters and compare logic live in c1_sweep_checker.

## Test plan
- f_in driven by an ideal C1 connected to vec, SETTLE=1, pulse start: done rises 512 cycles later, err_cnt=0, pass=1.
- f_in tied to 0: err_cnt=128 and pass=0. With FIRST_FAIL_EN, ff_vec=8'h08 and ff_valid=1.
- f_in driven by the inverted golden model: err_cnt=256. With FIRST_FAIL_EN, ff_vec=8'h00.
- SETTLE=3, ideal C1: done arrives after 1024 cycles, and vec holds each value for 4 cycles.
- start pulsed again at vec=8'h40 while busy: ignored, and the sweep still finishes at the original time.
- rst asserted at vec=8'h80 with err_cnt nonzero: all outputs return to reset values within the same cycle. A following start completes a clean sweep.

Source files
------------

// File: rtl/c1_pkg.sv
// Shared constants for the C1 sweep checker: vector layout, counter widths, FSM encodings.
package c1_pkg;

    localparam int unsigned VEC_W  = 8;
    localparam int unsigned WAIT_W = 4;
    localparam int unsigned ERR_W  = 9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit positions of the C1 inputs within vec, in C1 port order
    localparam int unsigned BIT_SB = 7;
    localparam int unsigned BIT_SA = 6;
    localparam int unsigned BIT_S1 = 5;
    localparam int unsigned BIT_S0 = 4;
    localparam int unsigned BIT_A0 = 3;
    localparam int unsigned BIT_B0 = 2;
    localparam int unsigned BIT_A1 = 1;
    localparam int unsigned BIT_B1 = 0;

endpackage

// File: rtl/c1_golden.sv
// Combinational reference model of the C1 logic-module cell.
module c1_golden
    import c1_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             f_c
);

    logic f1;
    logic f2;

    always_comb begin
        f1  = vec[BIT_SA] ? vec[BIT_A1] : vec[BIT_A0];
        f2  = vec[BIT_SB] ? vec[BIT_B1] : vec[BIT_B0];
        f_c = (vec[BIT_S0] | vec[BIT_S1]) ? f2 : f1;
    end

endmodule

// File: rtl/c1_sweep_checker.sv
// Exhaustive on-chip sweep of a C1 cell against a built-in golden model.
// Optional first-mismatch capture (ff_valid/ff_vec) when FIRST_FAIL_EN is defined.
module c1_sweep_checker
    import c1_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             f_in,
    output logic [VEC_W-1:0] vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
`ifdef FIRST_FAIL_EN
    ,
    output logic             ff_valid,
    output logic [VEC_W-1:0] ff_vec
`endif
);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic [VEC_W-1:0]  vec_d;
    logic [ERR_W-1:0]  err_d;
    logic              busy_d;
    logic              done_d;
    logic              pass_d;
    logic              golden_f;
    logic              start_acc_c;
    logic              cmp_edge_c;
    logic              mismatch_c;

    c1_golden u_golden (
        .vec (vec),
        .f_c (golden_f)
    );

    assign start_acc_c = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign cmp_edge_c  = (state_q == ST_RUN) && (wait_q == WAIT_W'(SETTLE));
    assign mismatch_c  = cmp_edge_c && (f_in != golden_f);

    // Next-state and result logic; the compare edge is where vec advances or the sweep ends
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        vec_d   = vec;
        err_d   = err_cnt;
        busy_d  = busy;
        done_d  = done;
        pass_d  = pass;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_acc_c) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                    vec_d   = '0;
                    err_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (cmp_edge_c) begin
                    wait_d = '0;
                    if (mismatch_c) begin
                        err_d = err_cnt + ERR_W'(1);
                    end
                    if (vec == {VEC_W{1'b1}}) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_d = vec + VEC_W'(1);
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            vec     <= '0;
            err_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            vec     <= vec_d;
            err_cnt <= err_d;
            busy    <= busy_d;
            done    <= done_d;
            pass    <= pass_d;
        end
    end

`ifdef FIRST_FAIL_EN
    logic             ff_valid_d;
    logic [VEC_W-1:0] ff_vec_d;

    // Latch only the first mismatch of a sweep
    always_comb begin
        ff_valid_d = ff_valid;
        ff_vec_d   = ff_vec;
        if (start_acc_c) begin
            ff_valid_d = 1'b0;
            ff_vec_d   = '0;
        end else if (mismatch_c && !ff_valid) begin
            ff_valid_d = 1'b1;
            ff_vec_d   = vec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff_valid <= 1'b0;
            ff_vec   <= '0;
        end else begin
            ff_valid <= ff_valid_d;
            ff_vec   <= ff_vec_d;
        end
    end
`endif

endmodule

// File: tb/tb_c1_sweep_checker.sv
// Scoreboard bench for c1_sweep_checker at SETTLE=1 and SETTLE=3, with a behavioural C1 model.
module tb_c1_sweep_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start3;
    logic        f_in;
    logic        f_in3;
    logic [7:0]  vec;
    logic [7:0]  vec3;
    logic        busy, done, pass;
    logic        busy3, done3, pass3;
    logic [8:0]  err_cnt;
    logic [8:0]  err_cnt3;
`ifdef FIRST_FAIL_EN
    logic        ff_valid, ff_valid3;
    logic [7:0]  ff_vec, ff_vec3;
`endif

    int          mode;
    logic [255:0] flips;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    typedef struct {
        int err;
        int ff;
        int done_cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // C1 behaviour: two 2:1 muxes feeding an output mux selected by S0|S1
    function automatic logic ref_f(input logic [7:0] v);
        logic sb_, sa, s1, s0, a0, b0, a1, b1;
        {sb_, sa, s1, s0, a0, b0, a1, b1} = v;
        if (s0 || s1) return sb_ ? b1 : b0;
        return sa ? a1 : a0;
    endfunction

    // Cell under test: 0 ideal, 1 stuck-at-0, 2 inverted, 3 random per-vector faults
    function automatic logic drive_f(input int m, input logic [255:0] fl, input logic [7:0] v);
        case (m)
            0:       return ref_f(v);
            1:       return 1'b0;
            2:       return !ref_f(v);
            default: return ref_f(v) ^ fl[v];
        endcase
    endfunction

    assign f_in  = drive_f(mode, flips, vec);
    assign f_in3 = ref_f(vec3);

    c1_sweep_checker #(.SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .f_in(f_in), .vec(vec),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
`ifdef FIRST_FAIL_EN
        , .ff_valid(ff_valid), .ff_vec(ff_vec)
`endif
    );

    c1_sweep_checker #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .f_in(f_in3), .vec(vec3),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err_cnt3)
`ifdef FIRST_FAIL_EN
        , .ff_valid(ff_valid3), .ff_vec(ff_vec3)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every rising done must match the oldest expected sweep result
    logic done_prev = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && done && !done_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("err_cnt", int'(err_cnt), e.err);
                check("pass", int'(pass), (e.err == 0) ? 1 : 0);
                check("done_cycle", cyc, e.done_cyc);
                check("busy_at_done", int'(busy), 0);
`ifdef FIRST_FAIL_EN
                check("ff_valid", int'(ff_valid), (e.ff >= 0) ? 1 : 0);
                check("ff_vec", int'(ff_vec), (e.ff >= 0) ? e.ff : 0);
`endif
            end
        end
        done_prev = done;
    end

    task automatic start_sweep(input int m, output int sedge);
        int e_err = 0;
        int e_ff  = -1;
        mode = m;
        for (int v = 0; v < 256; v++) begin
            if (drive_f(m, flips, 8'(v)) != ref_f(8'(v))) begin
                e_err++;
                if (e_ff < 0) e_ff = v;
            end
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        sedge = cyc;
        check("busy_after_start", int'(busy), 1);
        check("done_cleared", int'(done), 0);
        check("err_cleared", int'(err_cnt), 0);
        check("vec_cleared", int'(vec), 0);
        sb.push_back('{err: e_err, ff: e_ff, done_cyc: sedge + 512});
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("sweep_timeout", 1, 0);
            sb.delete();
        end
    endtask

    task automatic wait_vec(input logic [7:0] target, input int limit);
        int i = 0;
        while (vec != target && i < limit) begin
            @(negedge clk);
            i++;
        end
        check("reach_vec", int'(vec), int'(target));
    endtask

    initial begin
        int s;
        int last_chg, bad, changes, done3_cyc;
        logic [7:0] last_vec;
        rst = 1'b0; start = 1'b0; start3 = 1'b0; mode = 0; flips = '0;
        repeat (2) @(negedge clk);
        check("rst_vec", int'(vec), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_err", int'(err_cnt), 0);
`ifdef FIRST_FAIL_EN
        check("rst_ff_valid", int'(ff_valid), 0);
        check("rst_ff_vec", int'(ff_vec), 0);
`endif
        rst = 1'b1;

        // Ideal, stuck-at-0, inverted, then random fault patterns
        for (int m = 0; m < 3; m++) begin
            start_sweep(m, s);
            wait_idle(600);
        end
        for (int r = 0; r < 2; r++) begin
            flips = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
            start_sweep(3, s);
            wait_idle(600);
        end

        // start while busy must not restart the sweep
        start_sweep(0, s);
        wait_vec(8'h40, 300);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_idle(600);

        // start on the final compare edge is ignored; DONE holds
        start_sweep(0, s);
        repeat (511) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (2) @(negedge clk);
        check("done_held", int'(done), 1);
        check("busy_after_late_start", int'(busy), 0);
        check("sb_empty_after_late_start", sb.size(), 0);

        // Mid-sweep reset with accumulated errors
        start_sweep(1, s);
        wait_vec(8'h80, 400);
        check("err_at_80", int'(err_cnt), 64);
        rst = 1'b0;
        #1;
        check("abort_vec", int'(vec), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_pass", int'(pass), 0);
        check("abort_err", int'(err_cnt), 0);
`ifdef FIRST_FAIL_EN
        check("abort_ff_valid", int'(ff_valid), 0);
        check("abort_ff_vec", int'(ff_vec), 0);
`endif
        sb.delete();
        @(negedge clk) rst = 1'b1;
        start_sweep(0, s);
        wait_idle(600);

        // SETTLE=3: each vector held 4 cycles, done after 1024 cycles
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        s = cyc;
        check("busy3_after_start", int'(busy3), 1);
        last_chg = s; last_vec = vec3; bad = 0; changes = 0; done3_cyc = -1;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (vec3 != last_vec) begin
                if (cyc - last_chg != 4) bad++;
                changes++;
                last_chg = cyc;
                last_vec = vec3;
            end
            if (done3) begin
                done3_cyc = cyc;
                break;
            end
        end
        check("settle3_done_cycle", done3_cyc - s, 1024);
        check("settle3_hold_violations", bad, 0);
        check("settle3_vec_changes", changes, 255);
        check("settle3_err", int'(err_cnt3), 0);
        check("settle3_pass", int'(pass3), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
